// File: rtl/rect_draw.sv
// rect_draw: request-driven rectangle fill engine for the VGA adapter.
// Supports solid, outline, grid and full-screen modes. Every pixel is clipped
// to the screen, and the engine emits one pixel per clock.
module rect_draw #(
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int X_BITS      = 8,
    parameter int Y_BITS      = 7,
    parameter int COLOUR_BITS = 3,
    parameter int CELL        = 8
) (
    input  logic                   CLOCK_50,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [X_BITS-1:0]      x0,
    input  logic [Y_BITS-1:0]      y0,
    input  logic [X_BITS:0]        w,
    input  logic [Y_BITS:0]        h,
    input  logic [COLOUR_BITS-1:0] colour,
    output logic                   ready,
    output logic                   done,
    output logic [X_BITS-1:0]      VGA_X,
    output logic [Y_BITS-1:0]      VGA_Y,
    output logic [COLOUR_BITS-1:0] VGA_COLOUR,
    output logic                   VGA_PLOT
);

    localparam int G_BITS = $clog2(CELL);
    localparam logic [G_BITS-1:0] G_LAST = G_BITS'(CELL - 1);
    // The end sums use two extra bits so that x0+w cannot wrap before clipping.
    localparam logic [X_BITS+1:0] X_LIMIT = (X_BITS+2)'(SCREEN_W);
    localparam logic [Y_BITS+1:0] Y_LIMIT = (Y_BITS+2)'(SCREEN_H);
    localparam logic [X_BITS+1:0] X_ONE   = (X_BITS+2)'(1);
    localparam logic [Y_BITS+1:0] Y_ONE   = (Y_BITS+2)'(1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;
    typedef enum logic [1:0] {M_SOLID, M_OUTLINE, M_GRID, M_FULL} mode_t;

    state_t                 state, state_nxt;
    mode_t                  mode_r;
    logic [X_BITS-1:0]      x0_r, x_cnt, x_last;
    logic [Y_BITS-1:0]      y0_r, y_cnt, y_last;
    logic [X_BITS:0]        w_r;
    logic [Y_BITS:0]        h_r;
    logic [COLOUR_BITS-1:0] colour_r;
    logic [G_BITS-1:0]      gx, gy;

    logic [X_BITS+1:0]      x_sum, x_end;
    logic [Y_BITS+1:0]      y_sum, y_end;
    logic                   empty, row_end, last_pix, plot_px;

    assign VGA_X      = x_cnt;
    assign VGA_Y      = y_cnt;
    assign VGA_COLOUR = colour_r;

    // Clip the latched rectangle to the screen and classify the current pixel.
    always_comb begin
        x_sum    = {2'b00, x0_r} + {1'b0, w_r};
        y_sum    = {2'b00, y0_r} + {1'b0, h_r};
        x_end    = (x_sum > X_LIMIT) ? X_LIMIT : x_sum;
        y_end    = (y_sum > Y_LIMIT) ? Y_LIMIT : y_sum;
        empty    = ({2'b00, x0_r} >= x_end) || ({2'b00, y0_r} >= y_end);
        row_end  = (x_cnt == x_last);
        last_pix = row_end && (y_cnt == y_last);
        case (mode_r)
            M_OUTLINE: plot_px = (x_cnt == x0_r) || row_end ||
                                 (y_cnt == y0_r) || (y_cnt == y_last);
            M_GRID:    plot_px = (gx == '0) || (gy == '0) || row_end ||
                                 (y_cnt == y_last);
            default:   plot_px = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: sequential state always uses non-blocking assignment so that every
        // register samples the values from before the edge.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and handshake/plot outputs.
    always_comb begin
        // NOTE: every output gets a default first so that no path through the case infers a latch.
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        VGA_PLOT  = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = LOAD;
            end
            LOAD: state_nxt = empty ? DONE : DRAW;
            DRAW: begin
                VGA_PLOT = plot_px;
                if (last_pix) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, clip registration and raster scan counters.
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            mode_r   <= M_SOLID;
            x0_r     <= '0;
            y0_r     <= '0;
            w_r      <= '0;
            h_r      <= '0;
            colour_r <= '0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            x_last   <= '0;
            y_last   <= '0;
            gx       <= '0;
            gy       <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mode_r   <= mode_t'(mode);
                    colour_r <= colour;
                    if (mode_t'(mode) == M_FULL) begin
                        x0_r <= '0;
                        y0_r <= '0;
                        w_r  <= (X_BITS+1)'(SCREEN_W);
                        h_r  <= (Y_BITS+1)'(SCREEN_H);
                    end else begin
                        x0_r <= x0;
                        y0_r <= y0;
                        w_r  <= w;
                        h_r  <= h;
                    end
                end
                LOAD: begin
                    // The truncation is safe because a non-empty end lies in 1..SCREEN_W.
                    x_last <= X_BITS'(x_end - X_ONE);
                    y_last <= Y_BITS'(y_end - Y_ONE);
                    x_cnt  <= x0_r;
                    y_cnt  <= y0_r;
                    gx     <= '0;
                    gy     <= '0;
                end
                DRAW: begin
                    if (row_end) begin
                        x_cnt <= x0_r;
                        y_cnt <= y_cnt + 1'b1;
                        gx    <= '0;
                        gy    <= (gy == G_LAST) ? '0 : gy + 1'b1;
                    end else begin
                        x_cnt <= x_cnt + 1'b1;
                        gx    <= (gx == G_LAST) ? '0 : gx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
